// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Iteration counter width; never below one bit so WIDTH=2 still has a counter.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_add_n.sv
// N-bit ripple-carry adder assembled from single-bit full adders.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        fulladder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (w_c[i]),
            .s   (s[i]),
            .cout(w_c[i+1])
        );
    end
endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: WIDTH iterations per product, optional
// two's-complement mode via sign-magnitude conversion around an unsigned core.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mult;
    logic [WIDTH-1:0]   r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_final;
    logic [2*WIDTH-1:0] w_negd;
    logic [2*WIDTH-1:0] w_res;
    logic               w_unused_neg_cout;

    // Most-negative operand maps to 2^(WIDTH-1), which still fits as unsigned.
    assign w_a_mag  = (SIGNED != 0 && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_b_mag  = (SIGNED != 0 && b[WIDTH-1]) ? (~b + 1'b1) : b;
    assign w_addend = r_mult[0] ? r_mcand : '0;

    add_n #(.N(WIDTH)) u_acc_add (
        .a   (r_acc),
        .b   (w_addend),
        .cin (1'b0),
        .s   (w_sum),
        .cout(w_cout)
    );

    // {carry, sum, multiplier} shifted right once: the value after the final step.
    assign w_final = {w_cout, w_sum, r_mult[WIDTH-1:1]};

    add_n #(.N(2*WIDTH)) u_neg_add (
        .a   (~w_final),
        .b   ('0),
        .cin (1'b1),
        .s   (w_negd),
        .cout(w_unused_neg_cout)
    );

    assign w_res = (SIGNED != 0 && r_neg) ? w_negd : w_final;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mult    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mcand <= w_a_mag;
                        r_mult  <= w_b_mag;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_neg   <= (SIGNED != 0) ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc  <= {w_cout, w_sum[WIDTH-1:1]};
                    r_mult <= {w_sum[0], r_mult[WIDTH-1:1]};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_product <= w_res;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: three instances (4-bit unsigned, 8-bit unsigned, 8-bit signed)
// checked cycle-by-cycle against an arithmetic reference product.
module tb_seq_mult;
    logic        clk = 1'b0;
    logic        reset;
    logic        st [3];
    logic [7:0]  av [3];
    logic [7:0]  bv [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic [15:0] prod_v [3];
    logic [7:0]  prod0;
    logic [15:0] prod1;
    logic [15:0] prod2;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(4), .SIGNED(0)) u_w4u (
        .clk(clk), .reset(reset), .start(st[0]), .a(av[0][3:0]), .b(bv[0][3:0]),
        .busy(busy_v[0]), .done(done_v[0]), .product(prod0)
    );
    seq_mult #(.WIDTH(8), .SIGNED(0)) u_w8u (
        .clk(clk), .reset(reset), .start(st[1]), .a(av[1]), .b(bv[1]),
        .busy(busy_v[1]), .done(done_v[1]), .product(prod1)
    );
    seq_mult #(.WIDTH(8), .SIGNED(1)) u_w8s (
        .clk(clk), .reset(reset), .start(st[2]), .a(av[2]), .b(bv[2]),
        .busy(busy_v[2]), .done(done_v[2]), .product(prod2)
    );

    assign prod_v[0] = {8'h00, prod0};
    assign prod_v[1] = prod1;
    assign prod_v[2] = prod2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_prod(input int id, input logic [7:0] x, input logic [7:0] y);
        int p;
        if (id == 0)      p = int'(x[3:0]) * int'(y[3:0]);
        else if (id == 1) p = int'(x) * int'(y);
        else              p = int'($signed(x)) * int'($signed(y));
        return p[15:0];
    endfunction

    // Start in the current cycle; busy over cycles 1..W, done in cycle W+1.
    // hold: keep start high and scramble a/b while running. chain: return in the DONE cycle.
    task automatic run_op(input int id, input logic [7:0] oa, input logic [7:0] ob,
                          input bit hold, input bit chain);
        int          w;
        logic [15:0] exp_p;
        w     = (id == 0) ? 4 : 8;
        exp_p = ref_prod(id, oa, ob);
        st[id] = 1'b1; av[id] = oa; bv[id] = ob;
        tick();
        for (int k = 1; k <= w; k++) begin
            n_tests++;
            if (busy_v[id] !== 1'b1 || done_v[id] !== 1'b0) begin
                n_fail++;
                $display("FAIL run%0d_busy cyc%0d: busy/done=%b/%b want 1/0", id, k, busy_v[id], done_v[id]);
            end
            if (hold) begin
                av[id] = 8'($urandom);
                bv[id] = 8'($urandom);
            end else begin
                st[id] = 1'b0;
            end
            tick();
        end
        n_tests++;
        if (done_v[id] !== 1'b1 || busy_v[id] !== 1'b0 || prod_v[id] !== exp_p) begin
            n_fail++;
            $display("FAIL run%0d_done a=%h b=%h: done/busy=%b/%b prod=%h want 1/0 prod=%h",
                     id, oa, ob, done_v[id], busy_v[id], prod_v[id], exp_p);
        end
        if (!chain) begin
            st[id] = 1'b0;
            tick();
            n_tests++;
            if (done_v[id] !== 1'b0 || busy_v[id] !== 1'b0 || prod_v[id] !== exp_p) begin
                n_fail++;
                $display("FAIL run%0d_hold: done/busy=%b/%b prod=%h want 0/0 prod=%h",
                         id, done_v[id], busy_v[id], prod_v[id], exp_p);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin st[i] = 1'b1; av[i] = 8'hA5; bv[i] = 8'h3C; end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || prod_v[i] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset%0d: busy/done/prod=%b/%b/%h want 0/0/0", i, busy_v[i], done_v[i], prod_v[i]);
            end
            st[i] = 1'b0;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_op(0, 8'd15, 8'd15, 0, 0);
        run_op(1, 8'd255, 8'd255, 0, 0);
        run_op(1, 8'd0, 8'd200, 0, 0);
        run_op(2, 8'h80, 8'h80, 0, 0);
        run_op(2, 8'hFD, 8'd5, 0, 0);
        run_op(2, 8'd7, 8'hFF, 0, 0);
        run_op(2, 8'h80, 8'd1, 0, 0);
        run_op(2, 8'h00, 8'h9C, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++)
            for (int id = 0; id < 3; id++)
                run_op(id, 8'($urandom), 8'($urandom), 0, 0);
    endtask

    task automatic test_start_held();
        run_op(1, 8'($urandom), 8'($urandom), 1, 0);
        run_op(2, 8'($urandom), 8'($urandom), 1, 0);
        run_op(0, 8'($urandom), 8'($urandom), 1, 0);
    endtask

    task automatic test_back_to_back();
        run_op(1, 8'($urandom), 8'($urandom), 0, 1);
        run_op(1, 8'($urandom), 8'($urandom), 0, 1);
        run_op(1, 8'($urandom), 8'($urandom), 0, 0);
        run_op(2, 8'($urandom), 8'($urandom), 0, 1);
        run_op(2, 8'h80, 8'h7F, 0, 0);
    endtask

    task automatic test_reset_mid_op();
        run_op(1, 8'd200, 8'd3, 0, 0);
        st[1] = 1'b1; av[1] = 8'd99; bv[1] = 8'd77;
        tick();
        st[1] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0 || prod_v[1] !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy/done/prod=%b/%b/%h want 0/0/0", busy_v[1], done_v[1], prod_v[1]);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            n_tests++;
            if (done_v[1] !== 1'b0 || busy_v[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_quiet cyc%0d: done/busy=%b/%b want 0/0", k, done_v[1], busy_v[1]);
            end
        end
        run_op(1, 8'd99, 8'd77, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
